// File: rtl/jtpang_colmix_if.sv
// CPU-side palette bus of the colour mixer: write strobe, address, data and byte read-back.
interface jtpang_colmix_if;
  logic       pal_cs;
  logic       cpu_wrn;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_dout;
  logic [7:0] pal_dout;

  // A write happens on every clk with pal_cs=1 and cpu_wrn=0; there is no valid/ready
  // pairing because the palette never stalls. pal_dout follows cpu_addr one clk later.
  modport master (output pal_cs, cpu_wrn, cpu_addr, cpu_dout, input  pal_dout);
  modport slave  (input  pal_cs, cpu_wrn, cpu_addr, cpu_dout, output pal_dout);
endinterface

// File: rtl/jtpang_colmix.sv
// Pang colour mixer: picks obj/char palette entries by priority and looks them up in a
// CPU-writable 512-entry palette through a 3-stage pxl_cen pipeline.
module jtpang_colmix (
  input  logic              rst_n,
  input  logic              clk,
  input  logic              pxl_cen,
  input  logic              LHBL,
  input  logic              LVBL,
  input  logic [7:0]        char_pxl,
  input  logic [7:0]        obj_pxl,
  input  logic [1:0]        gfx_en,
  jtpang_colmix_if.slave    cpu,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              LHBL_dly,
  output logic              LVBL_dly
);

  // Even bytes {G,B} and odd bytes {x,R} live in separate banks so the video side
  // fetches a whole entry in a single clk.
  logic [7:0] r_pal_lo [0:511];
  logic [7:0] r_pal_hi [0:511];
  logic [7:0] r_pal_dout;

  logic       w_cpu_we;
  logic       w_obj_opaque;
  logic [8:0] w_sel;
  logic       w_s2_blank;

  logic [8:0] r_s1_idx;
  logic       r_s1_hb;
  logic       r_s1_vb;
  logic [7:0] r_s2_gb;
  logic [3:0] r_s2_r;
  logic       r_s2_hb;
  logic       r_s2_vb;

  assign w_cpu_we     = cpu.pal_cs & ~cpu.cpu_wrn;
  assign w_obj_opaque = gfx_en[1] & (obj_pxl[3:0] != 4'hF);
  assign w_s2_blank   = ~(r_s2_hb & r_s2_vb);
  assign cpu.pal_dout = r_pal_dout;

  always_comb begin
    w_sel = 9'h1FF;
    if (w_obj_opaque) begin
      w_sel = {1'b0, obj_pxl};
    end else if (gfx_en[0]) begin
      w_sel = {1'b1, char_pxl};
    end
  end

  // Palette contents survive reset; only the pipeline is cleared.
  always_ff @(posedge clk) begin
    if (w_cpu_we) begin
      if (cpu.cpu_addr[0]) begin
        r_pal_hi[cpu.cpu_addr[9:1]] <= cpu.cpu_dout;
      end else begin
        r_pal_lo[cpu.cpu_addr[9:1]] <= cpu.cpu_dout;
      end
    end
    r_pal_dout <= cpu.cpu_addr[0] ? r_pal_hi[cpu.cpu_addr[9:1]]
                                  : r_pal_lo[cpu.cpu_addr[9:1]];
  end

  // Stage 2 reads with non-blocking semantics, so a same-clk CPU write is seen one pixel later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_idx <= 9'd0;
      r_s1_hb  <= 1'b0;
      r_s1_vb  <= 1'b0;
      r_s2_gb  <= 8'd0;
      r_s2_r   <= 4'd0;
      r_s2_hb  <= 1'b0;
      r_s2_vb  <= 1'b0;
      red      <= 4'd0;
      green    <= 4'd0;
      blue     <= 4'd0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else if (pxl_cen) begin
      r_s1_idx <= w_sel;
      r_s1_hb  <= LHBL;
      r_s1_vb  <= LVBL;
      r_s2_gb  <= r_pal_lo[r_s1_idx];
      r_s2_r   <= r_pal_hi[r_s1_idx][3:0];
      r_s2_hb  <= r_s1_hb;
      r_s2_vb  <= r_s1_vb;
      red      <= w_s2_blank ? 4'd0 : r_s2_r;
      green    <= w_s2_blank ? 4'd0 : r_s2_gb[7:4];
      blue     <= w_s2_blank ? 4'd0 : r_s2_gb[3:0];
      LHBL_dly <= r_s2_hb;
      LVBL_dly <= r_s2_vb;
    end
  end

endmodule

// File: tb/tb_jtpang_colmix.sv
// Bench for jtpang_colmix: palette/pixel reference model with a per-cycle compare,
// directed literal scenarios and a randomized phase.
module tb_jtpang_colmix;

  logic       clk;
  logic       rst_n;
  logic       pxl_cen;
  logic       LHBL;
  logic       LVBL;
  logic [7:0] char_pxl;
  logic [7:0] obj_pxl;
  logic [1:0] gfx_en;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       LHBL_dly;
  logic       LVBL_dly;

  jtpang_colmix_if bus ();

  jtpang_colmix dut (
    .rst_n    (rst_n),
    .clk      (clk),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .char_pxl (char_pxl),
    .obj_pxl  (obj_pxl),
    .gfx_en   (gfx_en),
    .cpu      (bus),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] vid();
    return {2'b00, LHBL_dly, LVBL_dly, red, green, blue};
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]  pal_m   [0:1023];
  bit          written [0:1023];
  logic [10:0] pix_q [$];   // {LHBL, LVBL, entry} sampled but not yet looked up
  logic [13:0] exp_q [$];   // {LHBL, LVBL, R, G, B} looked up, waiting to show
  logic [13:0] exp_vid;
  logic [7:0]  exp_pd;
  bit          pd_known;
  bit          started;

  function automatic logic [8:0] pick_entry(input logic [7:0] obj, input logic [7:0] chr,
                                            input logic [1:0] en);
    if (en[1] && obj[3:0] != 4'hF) return {1'b0, obj};
    if (en[0]) return {1'b1, chr};
    return 9'h1FF;
  endfunction

  function automatic logic [13:0] look_up(input logic [10:0] p);
    int base;
    base = 2 * int'(p[8:0]);
    if (p[10] && p[9])
      return {2'b11, pal_m[base + 1][3:0], pal_m[base]};
    return {p[10], p[9], 12'h000};
  endfunction

  task automatic model_reset();
    pix_q   = '{11'h000};
    exp_q   = '{14'h0000};
    exp_vid = 14'h0000;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n === 1'b1 && pxl_cen) begin
      exp_vid = exp_q.pop_front();
      while (pix_q.size() > 0) exp_q.push_back(look_up(pix_q.pop_front()));
      pix_q.push_back({LHBL, LVBL, pick_entry(obj_pxl, char_pxl, gfx_en)});
    end
    pd_known = written[bus.cpu_addr];
    exp_pd   = pal_m[bus.cpu_addr];
    if (bus.pal_cs && !bus.cpu_wrn) begin
      pal_m[bus.cpu_addr]   = bus.cpu_dout;
      written[bus.cpu_addr] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("video", vid(), {2'b00, exp_vid});
      if (pd_known) chk("pal_dout", {8'h00, bus.pal_dout}, {8'h00, exp_pd});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_wr(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.pal_cs = 1'b1; bus.cpu_wrn = 1'b0; bus.cpu_addr = a; bus.cpu_dout = d;
    @(negedge clk);
    bus.pal_cs = 1'b0; bus.cpu_wrn = 1'b1;
  endtask

  task automatic set_pix(input logic [7:0] obj, input logic [7:0] chr, input logic [1:0] en,
                         input logic hb, input logic vb);
    obj_pxl = obj; char_pxl = chr; gfx_en = en; LHBL = hb; LVBL = vb;
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      @(negedge clk) pxl_cen = 1'b1;
      @(negedge clk) pxl_cen = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; pxl_cen = 1'b0;
    set_pix(8'h00, 8'h00, 2'b11, 1'b1, 1'b1);
    bus.pal_cs = 1'b0; bus.cpu_wrn = 1'b1; bus.cpu_addr = '0; bus.cpu_dout = '0;
    for (int i = 0; i < 1024; i++) written[i] = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    started = 1'b1;
    chk("reset_outputs", vid(), 16'h0000);

    // Fill the palette while reset holds the pipeline; CPU access ignores reset.
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      bus.pal_cs = 1'b1; bus.cpu_wrn = 1'b0; bus.cpu_addr = 10'(i); bus.cpu_dout = 8'($urandom);
    end
    @(negedge clk);
    bus.pal_cs = 1'b0; bus.cpu_wrn = 1'b1;
    chk("reset_held_outputs", vid(), 16'h0000);
    rst_n = 1'b1;

    cpu_wr(10'h000, 8'h5A); cpu_wr(10'h001, 8'h03);
    cpu_wr(10'h224, 8'h21); cpu_wr(10'h225, 8'h0C);
    cpu_wr(10'h3FE, 8'h76); cpu_wr(10'h3FF, 8'h09);

    // Opaque obj colour 0 of palette 0.
    set_pix(8'h00, 8'h12, 2'b11, 1'b1, 1'b1);
    pulses(2);
    chk("latency_not_yet", vid(), 16'h0000);
    pulses(1);
    chk("obj_entry0", vid(), 16'h335A);

    // Transparent obj falls through to char, then to the backdrop entry.
    set_pix(8'h0F, 8'h12, 2'b11, 1'b1, 1'b1);
    pulses(3);
    chk("char_entry112", vid(), 16'h3C21);
    set_pix(8'h0F, 8'h12, 2'b10, 1'b1, 1'b1);
    pulses(3);
    chk("char_off_1ff", vid(), 16'h3976);
    set_pix(8'h00, 8'h12, 2'b00, 1'b1, 1'b1);
    pulses(3);
    chk("both_off_1ff", vid(), 16'h3976);

    // Same-clk write and stage-2 read of entry 0.
    set_pix(8'h00, 8'h12, 2'b11, 1'b1, 1'b1);
    pulses(1);
    @(negedge clk);
    pxl_cen = 1'b1;
    bus.pal_cs = 1'b1; bus.cpu_wrn = 1'b0; bus.cpu_addr = 10'h000; bus.cpu_dout = 8'hC3;
    @(negedge clk);
    pxl_cen = 1'b0; bus.pal_cs = 1'b0; bus.cpu_wrn = 1'b1;
    pulses(1);
    chk("collide_old", vid(), 16'h335A);
    pulses(1);
    chk("collide_new", vid(), 16'h33C3);
    chk("readback_new", {8'h00, bus.pal_dout}, 16'h00C3);

    // One blanked pixel.
    set_pix(8'h00, 8'h12, 2'b11, 1'b0, 1'b1);
    pulses(1);
    set_pix(8'h00, 8'h12, 2'b11, 1'b1, 1'b1);
    pulses(2);
    chk("hblank_pixel", vid(), 16'h1000);
    pulses(1);
    chk("after_hblank", vid(), 16'h33C3);

    // Asynchronous reset mid-line.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", vid(), 16'h0000);
    bus.cpu_addr = 10'h224;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("palette_survives_reset", {8'h00, bus.pal_dout}, 16'h0021);
    set_pix(8'h0F, 8'h12, 2'b11, 1'b1, 1'b1);
    pulses(2);
    chk("post_reset_2nd", vid(), 16'h0000);
    pulses(1);
    chk("post_reset_3rd", vid(), 16'h3C21);

    // pxl_cen gap with CPU writes; the per-cycle compare checks the outputs hold.
    set_pix(8'h00, 8'h12, 2'b11, 1'b1, 1'b1);
    pulses(3);
    chk("pre_gap", vid(), 16'h33C3);
    cpu_wr(10'h000, 8'h11); cpu_wr(10'h001, 8'h0E);
    cpu_wr(10'h100, 8'h44); cpu_wr(10'h101, 8'h05);
    repeat (2) @(negedge clk);
    chk("gap_hold", vid(), 16'h33C3);
    set_pix(8'h0F, 8'h12, 2'b11, 1'b1, 1'b1);
    pulses(1);
    chk("resume_1", vid(), 16'h33C3);
    pulses(1);
    chk("resume_2", vid(), 16'h3E11);
    pulses(1);
    chk("resume_3", vid(), 16'h3C21);

    // Randomized traffic on both ports.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      pxl_cen  = ($urandom_range(0, 2) == 0);
      obj_pxl  = 8'($urandom);
      if ($urandom_range(0, 2) == 0) obj_pxl[3:0] = 4'hF;
      char_pxl = 8'($urandom);
      gfx_en   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      LHBL     = ($urandom_range(0, 7) != 0);
      LVBL     = ($urandom_range(0, 15) != 0);
      bus.cpu_addr = 10'($urandom);
      bus.cpu_dout = 8'($urandom);
      bus.pal_cs   = ($urandom_range(0, 3) == 0);
      bus.cpu_wrn  = ($urandom_range(0, 1) == 0);
    end
    @(negedge clk);
    pxl_cen = 1'b0; bus.pal_cs = 1'b0; bus.cpu_wrn = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
